// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel serial front end.
package led_panel_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  localparam int CMD_BIT = 7;
  localparam int RGB_W   = 3;

  // Clock cycles per serial bit.
  function automatic int calc_cpb(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchronizer, bit-timing FSM and sampling.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_rx_core
  import led_panel_pkg::*;
#(
  parameter int CPB = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  logic [1:0]       sync_q;
  logic             s;
  logic             line;
  logic             samp;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], uart_data};
  end

  assign s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // The FSM watches s one cycle late, so the window {s_d2, s_d1, s} at its
  // sample cycle is centred on the nominal target cycle.
  logic s_d1, s_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d1 <= 1'b1;
      s_d2 <= 1'b1;
    end else begin
      s_d1 <= s;
      s_d2 <= s_d1;
    end
  end

  assign line = s_d1;
  assign samp = (s & s_d1) | (s & s_d2) | (s_d1 & s_d2);
`else
  assign line = s;
  assign samp = s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!line) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = samp ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          shreg_d = {samp, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          if (samp) begin
            byte_valid = 1'b1;
            state_d    = RX_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        cnt_d = '0;
        if (line) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  assign byte_data = shreg_q;

endmodule

// File: rtl/uart_pixel_rx.sv
// UART-to-framebuffer front end: byte decode and wrapping pixel address.
// Build option: UART_RX_MAJORITY_EN (majority sampling in uart_rx_core).
module uart_pixel_rx
  import led_panel_pkg::*;
#(
  parameter int CLOCK_RATE = 1000,
  parameter int BAUD_RATE  = 100,
  parameter int PIXELS     = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_data,
  output logic                       pix_we,
  output logic [$clog2(PIXELS)-1:0]  pix_addr,
  output logic [RGB_W-1:0]           pix_rgb,
  output logic                       frame_start,
  output logic                       frame_err
);

  localparam int                 CPB       = calc_cpb(CLOCK_RATE, BAUD_RATE);
  localparam int                 ADDR_W    = $clog2(PIXELS);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(PIXELS - 1);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              rx_err;
  logic [ADDR_W-1:0] addr_q;
  logic              unused_bits;

  uart_rx_core #(.CPB(CPB)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_data  (uart_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (rx_err)
  );

  // Payload bits 6:3 carry no meaning for either byte type.
  assign unused_bits = ^byte_data[6:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pix_we      <= 1'b0;
      frame_start <= 1'b0;
      frame_err   <= rx_err;
      if (byte_valid) begin
        if (byte_data[CMD_BIT]) begin
          addr_q      <= '0;
          frame_start <= 1'b1;
        end else begin
          pix_we   <= 1'b1;
          pix_addr <= addr_q;
          pix_rgb  <= byte_data[RGB_W-1:0];
          addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_rx.sv
// Directed self-checking bench for uart_pixel_rx (PIXELS = 5, CPB = 10).
module tb_uart_pixel_rx;

  localparam int CLOCK_RATE = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int PIXELS     = 5;
  localparam int CPB        = 10;
  localparam int HALF       = 5;
  localparam int CHAR       = 10 * CPB;
  localparam int ADDR_W     = 3;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 99;
`else
  localparam int LAT = 98;
`endif
  localparam int K_WR = 0, K_FS = 1, K_ERR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              uart_data;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [2:0]        pix_rgb;
  logic              frame_start;
  logic              frame_err;

  typedef struct {
    int kind;
    int addr;
    int rgb;
    int cyc;
  } ev_t;

  ev_t ev_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  excl_viol = 0;
  int  consec_viol = 0;
  bit  prev_any = 1'b0;
  int  last_cyc;
  int  exp_addr;

  uart_pixel_rx #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .PIXELS     (PIXELS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_data   (uart_data),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    int  n;
    if (rst_n) begin
      n = int'(pix_we) + int'(frame_start) + int'(frame_err);
      e.cyc  = cyc;
      e.addr = int'(pix_addr);
      e.rgb  = int'(pix_rgb);
      if (pix_we)      begin e.kind = K_WR;  ev_q.push_back(e); end
      if (frame_start) begin e.kind = K_FS;  ev_q.push_back(e); end
      if (frame_err)   begin e.kind = K_ERR; ev_q.push_back(e); end
      if (n > 1) excl_viol++;
      if (n > 0 && prev_any) consec_viol++;
      prev_any = (n > 0);
    end else begin
      prev_any = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Pops the oldest strobe; gap > 0 also checks cycles since last_cyc.
  task automatic expect_ev(input string tag, input int kind, input int addr,
                           input int rgb, input int gap);
    ev_t e;
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
    end else begin
      e.kind = -1; e.addr = -1; e.rgb = -1; e.cyc = -1;
    end
    check({tag, ".kind"}, e.kind, kind);
    if (kind == K_WR) begin
      check({tag, ".addr"}, e.addr, addr);
      check({tag, ".rgb"}, e.rgb, rgb);
    end
    if (gap > 0) check({tag, ".gap"}, e.cyc - last_cyc, gap);
    last_cyc = e.cyc;
  endtask

  task automatic idle(input int n);
    uart_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 character; glitch >= 0 inverts the line for that one cycle.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int glitch);
    logic v;
    int   bi;
    for (int k = 0; k < CHAR; k++) begin
      bi = k / CPB;
      if (bi == 0)      v = 1'b0;
      else if (bi == 9) v = stop_ok;
      else              v = b[bi-1];
      if (k == glitch) v = ~v;
      uart_data = v;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    uart_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("rst.pix_we", pix_we, 0);
    check("rst.frame_start", frame_start, 0);
    check("rst.frame_err", frame_err, 0);
    check("rst.pix_addr", pix_addr, 0);
    check("rst.pix_rgb", pix_rgb, 0);

    // Command then three pixels, back to back.
    last_cyc = cyc;
    send(8'h80, 1'b1, -1);
    send(8'h01, 1'b1, -1);
    send(8'h02, 1'b1, -1);
    send(8'h03, 1'b1, -1);
    idle(CPB);
    expect_ev("stream.fs", K_FS, 0, 0, LAT);
    expect_ev("stream.w0", K_WR, 0, 1, CHAR);
    expect_ev("stream.w1", K_WR, 1, 2, CHAR);
    expect_ev("stream.w2", K_WR, 2, 3, CHAR);
    check("stream.extra", ev_q.size(), 0);

    // Reset in the middle of a character.
    for (int k = 0; k < 4 * CPB; k++) begin
      uart_data = (k < CPB) ? 1'b0 : 1'(k / CPB);
      @(negedge clk);
    end
    rst_n     = 1'b0;
    uart_data = 1'b1;
    @(negedge clk);
    check("midrst.pix_addr", pix_addr, 0);
    check("midrst.pix_rgb", pix_rgb, 0);
    check("midrst.pix_we", pix_we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3 * CPB);
    check("midrst.no_strobe", ev_q.size(), 0);
    send(8'h05, 1'b1, -1);
    idle(CPB);
    expect_ev("midrst.w", K_WR, 0, 5, 0);
    idle(CPB);
    check("hold.pix_we", pix_we, 0);
    check("hold.pix_addr", pix_addr, 0);
    check("hold.pix_rgb", pix_rgb, 5);

    // Address wrap at PIXELS = 5; payload bits 6:3 are ignored.
    last_cyc = cyc;
    send(8'hC3, 1'b1, -1);
    send(8'h01, 1'b1, -1);
    send(8'h7A, 1'b1, -1);
    send(8'h0B, 1'b1, -1);
    send(8'h44, 1'b1, -1);
    send(8'h15, 1'b1, -1);
    send(8'h66, 1'b1, -1);
    send(8'h37, 1'b1, -1);
    idle(CPB);
    expect_ev("wrap.fs", K_FS, 0, 0, LAT);
    expect_ev("wrap.w0", K_WR, 0, 1, CHAR);
    expect_ev("wrap.w1", K_WR, 1, 2, CHAR);
    expect_ev("wrap.w2", K_WR, 2, 3, CHAR);
    expect_ev("wrap.w3", K_WR, 3, 4, CHAR);
    expect_ev("wrap.w4", K_WR, 4, 5, CHAR);
    expect_ev("wrap.w5", K_WR, 0, 6, CHAR);
    expect_ev("wrap.w6", K_WR, 1, 7, CHAR);
    check("wrap.extra", ev_q.size(), 0);

    // Bad stop bit, line low for three bit times, then a good pixel.
    last_cyc = cyc;
    send(8'h41, 1'b0, -1);
    uart_data = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    idle(2 * CPB);
    send(8'h07, 1'b1, -1);
    idle(CPB);
    expect_ev("ferr.err", K_ERR, 0, 0, LAT);
    expect_ev("ferr.w", K_WR, 2, 7, 0);
    check("ferr.extra", ev_q.size(), 0);

    // Short low glitch is a false start.
    uart_data = 1'b0;
    repeat (HALF - 2) @(negedge clk);
    idle(3 * CPB);
    check("fstart.no_strobe", ev_q.size(), 0);
    send(8'h06, 1'b1, -1);
    idle(CPB);
    expect_ev("fstart.w", K_WR, 3, 6, 0);
    exp_addr = 4;
`ifdef UART_RX_MAJORITY_EN
    // One-cycle glitch exactly on the data bit 1 sample point.
    send(8'h2A, 1'b1, 2 * CPB + HALF);
    idle(CPB);
    expect_ev("maj.w", K_WR, 4, 2, 0);
    exp_addr = 0;
`endif

    // Sixteen back-to-back pixels.
    last_cyc = cyc;
    for (int i = 0; i < 16; i++) send(8'((i << 3) | ((i + 5) % 8)), 1'b1, -1);
    idle(CPB);
    for (int i = 0; i < 16; i++) begin
      expect_ev($sformatf("b2b.w%0d", i), K_WR, exp_addr, (i + 5) % 8,
                (i == 0) ? LAT : CHAR);
      exp_addr = (exp_addr + 1) % PIXELS;
    end
    check("b2b.extra", ev_q.size(), 0);

    // Break: line held low gives exactly one framing error.
    last_cyc  = cyc;
    uart_data = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    expect_ev("break.err", K_ERR, 0, 0, LAT);
    check("break.single", ev_q.size(), 0);
    idle(3 * CPB);
    send(8'h04, 1'b1, -1);
    idle(CPB);
    expect_ev("break.recover", K_WR, exp_addr, 4, 0);

    check("strobes.exclusive", excl_viol, 0);
    check("strobes.not_consecutive", consec_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
